// File: rtl/hier_lane_arbiter_pkg.sv
// Shared types and constants for the hierarchical lane arbiter slice.
// Optional statistics counters are enabled with the HLA_STATS_EN macro.
package hier_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int unsigned LANE_W_DEF = 3;
    localparam int unsigned STAT_W     = 16;

    // Width of a requester index for n requesters.
    function automatic int unsigned src_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/hier_lane_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or above rr_ptr, wrapping.
module hla_rr_pick
    import hier_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [src_w(NUM_REQ)-1:0]   rr_ptr,
    output logic                        any,
    output logic [src_w(NUM_REQ)-1:0]   index
);

    localparam int unsigned SRC_W = src_w(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [SRC_W-1:0]   w_off;
    logic [SRC_W:0]     w_sum;

    // Rotate requests so rr_ptr sits at bit 0, find the nearest one, map back to an index.
    always_comb begin
        w_rot = NUM_REQ'({req, req} >> rr_ptr);
        any   = 1'b0;
        w_off = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (w_rot[k-1]) begin
                any   = 1'b1;
                w_off = SRC_W'(k - 1);
            end
        end
        w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
        if (w_sum >= (SRC_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (SRC_W+1)'(NUM_REQ);
        end
        index = w_sum[SRC_W-1:0];
    end

endmodule

// File: rtl/hier_lane_arbiter.sv
// Round-robin burst arbiter driving one shared, registered lane group.
// Define HLA_STATS_EN to add the per-requester grant_cnt statistics port.
module hier_lane_arbiter
    import hier_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned LANE_W    = LANE_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*LANE_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [LANE_W-1:0]           out_data,
    output logic [src_w(NUM_REQ)-1:0]   out_src,
    output logic                        out_last,
    input  logic                        out_ready
`ifdef HLA_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]   grant_cnt
`endif
);

    localparam int unsigned SRC_W = src_w(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    state_e             r_state;
    logic [SRC_W-1:0]   r_owner;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_out_valid;
    logic [LANE_W-1:0]  r_out_data;
    logic [SRC_W-1:0]   r_out_src;
    logic               r_out_last;

    logic               w_any;
    logic [SRC_W-1:0]   w_pick;
    logic               w_slot;
    logic               w_own_valid;
    logic               w_own_last;
    logic [LANE_W-1:0]  w_beat;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_accept;
    logic               w_end;

    hla_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .index  (w_pick)
    );

    // Select the owner's beat and drive its ready when the output register can take a beat.
    always_comb begin
        w_slot      = !r_out_valid || out_ready;
        w_req_ready = '0;
        w_beat      = '0;
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == SRC_W'(i)) begin
                w_beat      = req_data[i*LANE_W +: LANE_W];
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                if (r_state == GRANT) begin
                    w_req_ready[i] = w_slot;
                end
            end
        end
        w_accept = (r_state == GRANT) && w_own_valid && w_slot;
        w_end    = w_own_last || (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    end

    // Arbitration FSM, burst counter and shared-lane output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        if (w_end) begin
                            r_beat_cnt <= '0;
                            r_rr_ptr   <= (r_owner == SRC_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_beat;
                r_out_src   <= r_owner;
                r_out_last  <= w_end;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_last  = r_out_last;

`ifdef HLA_STATS_EN
    logic [STAT_W-1:0] r_grant_cnt [NUM_REQ];

    // Count IDLE->GRANT transitions per requester, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if ((r_state == IDLE) && w_any) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if ((w_pick == SRC_W'(i)) && (r_grant_cnt[i] != '1)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Flatten the counters onto the statistics port.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*STAT_W +: STAT_W] = r_grant_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_hier_lane_arbiter.sv
// Self-checking bench for hier_lane_arbiter (build with HLA_STATS_EN to check grant_cnt).
module tb_hier_lane_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned LW = 3;
    localparam int unsigned MB = 4;
    localparam int unsigned SW = 1;

    typedef struct packed {
        logic [LW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [LW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*LW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [LW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_last;
    logic              out_ready;
`ifdef HLA_STATS_EN
    logic [N*16-1:0]   grant_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    beat_t       src_q [N][$];
    exp_t        exp_q [$];
    int unsigned m_ptr;
    int unsigned m_grants [N];
    bit          chk_r1;

    always #5 clk = ~clk;

    hier_lane_arbiter #(
        .NUM_REQ   (N),
        .LANE_W    (LW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef HLA_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_rand_burst(input int unsigned r, input int unsigned len);
        for (int unsigned b = 0; b < len; b++) begin
            src_q[r].push_back('{d: LW'($urandom), l: (b == len - 1)});
        end
    endtask

    // Transaction-level model: serve non-empty queues round-robin, one burst per grant,
    // a burst ends at a last beat or after MB beats.
    function automatic void build_expected();
        beat_t mq [N][$];
        for (int unsigned i = 0; i < N; i++) mq[i] = src_q[i];
        forever begin
            int found = -1;
            for (int unsigned k = 0; k < N; k++) begin
                int unsigned j = (m_ptr + k) % N;
                if (found < 0 && mq[j].size() > 0) found = int'(j);
            end
            if (found < 0) break;
            m_grants[found]++;
            for (int unsigned n = 1; ; n++) begin
                beat_t b = mq[found].pop_front();
                logic  last = b.l || (n == MB) || (mq[found].size() == 0);
                exp_q.push_back('{d: b.d, s: SW'(found), l: b.l || (n == MB)});
                if (last) break;
            end
            m_ptr = (int'(found) + 1) % N;
        end
    endfunction

    task automatic drive_inputs();
        for (int unsigned i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]            = 1'b1;
                req_data[i*LW +: LW]    = src_q[i][0].d;
                req_last[i]             = src_q[i][0].l;
            end else begin
                req_valid[i]            = 1'b0;
                req_data[i*LW +: LW]    = LW'($urandom);
                req_last[i]             = 1'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            src_q[i].delete();
            m_grants[i] = 0;
        end
        exp_q.delete();
        m_ptr = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_src",   out_src,   0);
        check("rst_out_last",  out_last,  0);
        check("rst_req_ready", req_ready, 0);
`ifdef HLA_STATS_EN
        check("rst_grant_cnt", grant_cnt, 0);
`endif
        rst = 1'b0;
    endtask

    function automatic logic pick_ready(input int mode, inout int unsigned hold_cnt);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2 && out_valid && hold_cnt < 5) begin
            hold_cnt++;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // mode: 0 ready always, 1 random ready, 2 ready low for 5 cycles once a beat is held.
    // stop_after: 0 runs until the expected stream drains, else stops after that many accepts.
    task automatic run(input int mode, input int unsigned stop_after);
        int unsigned   hold_cnt = 0;
        int unsigned   cyc      = 0;
        int unsigned   accepted = 0;
        logic [N-1:0]  acc;
        logic          fire;
        logic          pv_hold  = 1'b0;
        logic [LW+SW:0] saved   = '0;
        exp_t          e;
        drive_inputs();
        out_ready = pick_ready(mode, hold_cnt);
        while (cyc < 2000 && exp_q.size() > 0 &&
               !(stop_after != 0 && accepted >= stop_after)) begin
            @(negedge clk);
            cyc++;
            check("ready_onehot", ($countones(req_ready) <= 1), 1);
            if (out_valid && !out_ready) check("ready_bp", req_ready, 0);
            if (pv_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_beat", {out_data, out_src, out_last}, saved);
            end
            if (chk_r1) check("r1_ready", req_ready[1], 0);
            fire = out_valid && out_ready;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", fire, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {out_data, out_src, out_last}, {e.d, e.s, e.l});
                end
            end
            pv_hold = out_valid && !out_ready;
            saved   = {out_data, out_src, out_last};
            acc     = req_valid & req_ready;
            accepted += $countones(acc);
            @(posedge clk); #1;
            for (int unsigned i = 0; i < N; i++) begin
                if (acc[i]) void'(src_q[i].pop_front());
            end
            drive_inputs();
            out_ready = pick_ready(mode, hold_cnt);
        end
        if (stop_after == 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        chk_r1 = 1'b0;
        do_reset();

        // req0 alone, two-beat burst; req1 must never see ready
        src_q[0].push_back('{d: 3'b101, l: 1'b0});
        src_q[0].push_back('{d: 3'b010, l: 1'b1});
        build_expected();
        chk_r1 = 1'b1;
        run(0, 0);
        chk_r1 = 1'b0;

        // both requesters with single-beat bursts alternate
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add_rand_burst(0, 1);
            add_rand_burst(1, 1);
        end
        build_expected();
        run(0, 0);

        // six-beat burst on req1 is cut after MB beats, remainder is a new burst
        add_rand_burst(1, 6);
        build_expected();
        run(0, 0);

        // backpressure: output held for five cycles
        add_rand_burst(0, 3);
        add_rand_burst(1, 2);
        build_expected();
        run(2, 0);

        // reset in the middle of a req1 burst; rr pointer must return to req0
        do_reset();
        add_rand_burst(0, 1);
        build_expected();
        run(0, 0);
        add_rand_burst(1, 4);
        build_expected();
        run(0, 2);
        do_reset();
        add_rand_burst(0, 1);
        add_rand_burst(1, 1);
        build_expected();
        run(0, 0);

`ifdef HLA_STATS_EN
        // grant statistics: three grants to req0, two to req1
        do_reset();
        for (int k = 0; k < 3; k++) add_rand_burst(0, $urandom_range(1, 2));
        for (int k = 0; k < 2; k++) add_rand_burst(1, $urandom_range(1, 2));
        build_expected();
        run(0, 0);
        check("grant_cnt", grant_cnt, {16'(m_grants[1]), 16'(m_grants[0])});
`endif

        // randomized traffic with random backpressure
        for (int round = 0; round < 8; round++) begin
            for (int unsigned r = 0; r < N; r++) begin
                int unsigned nb = $urandom_range(0, 3);
                for (int unsigned b = 0; b < nb; b++) add_rand_burst(r, $urandom_range(1, 6));
            end
            build_expected();
            run(1, 0);
        end
`ifdef HLA_STATS_EN
        check("grant_cnt_rand", grant_cnt, {16'(m_grants[1]), 16'(m_grants[0])});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
